// File: rtl/do_funct_pkg.sv
// do_funct_pkg: shared function/mode codes, channel state encoding and target rule
package do_funct_pkg;
  localparam logic [3:0] DO_FUNCT_LEVEL  = 4'd0;
  localparam logic [3:0] DO_FUNCT_HALL_A = 4'd1;
  localparam logic [3:0] DO_FUNCT_HALL_B = 4'd2;
  localparam logic [3:0] DO_FUNCT_HALL_C = 4'd3;
  localparam logic [3:0] DO_FUNCT_ENC_A1 = 4'd4;
  localparam logic [3:0] DO_FUNCT_ENC_B1 = 4'd5;
  localparam logic [3:0] DO_FUNCT_ENC_I1 = 4'd6;
  localparam logic [3:0] DO_FUNCT_ENC_A2 = 4'd7;
  localparam logic [3:0] DO_FUNCT_ENC_B2 = 4'd8;
  localparam logic [3:0] DO_FUNCT_ENC_I2 = 4'd9;
  localparam logic [3:0] DO_FUNCT_PWM    = 4'd10;
  typedef enum logic [1:0] {MODE_PP, MODE_OC, MODE_OE, MODE_DIS} mode_t;
  typedef enum logic [1:0] {ST_OFF, ST_HIGH, ST_LOW, ST_DEAD} state_t;
  function automatic state_t target_of(input logic l, input mode_t m);
    return m == MODE_PP ? (l ? ST_HIGH : ST_LOW) :
           m == MODE_OC ? (l ? ST_OFF : ST_LOW) :
           m == MODE_OE ? (l ? ST_HIGH : ST_OFF) : ST_OFF;
  endfunction
endpackage

// File: rtl/do_funct_sel_dt_if.sv
// do_funct_sel_dt_if: configuration inputs and pin-driver outputs of the DO selector
interface do_funct_sel_dt_if #(
  parameter int NCH = 8,
  parameter int NFUNCT = 10,
  parameter int FUNCT_W = 4,
  parameter int DT_W = 8
);
  logic [NCH*FUNCT_W-1:0] which_function;
  logic [NCH*2-1:0] which_mode;
  logic [NCH-1:0] level;
  logic [NFUNCT-1:0] function_signals_in;
  logic [DT_W-1:0] dead_time;
  logic [NCH-1:0] out_top;
  logic [NCH-1:0] out_bot;
  logic [NCH-1:0] dead_active;
  modport master (
    output which_function, which_mode, level, function_signals_in, dead_time,
    input out_top, out_bot, dead_active
  );
  modport slave (
    input which_function, which_mode, level, function_signals_in, dead_time,
    output out_top, out_bot, dead_active
  );
endinterface

// File: rtl/do_chan_dt.sv
// do_chan_dt: one DO channel with source select, target register and dead-time FSM
module do_chan_dt
  import do_funct_pkg::*;
#(
  parameter int NFUNCT = 10,
  parameter int FUNCT_W = 4,
  parameter int DT_W = 8
) (
  input  logic xclk,
  input  logic reset,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [1:0] mode,
  input  logic level,
  input  logic [NFUNCT-1:0] fsig,
  input  logic [DT_W-1:0] dead_time,
  output logic out_top,
  output logic out_bot,
  output logic dead_active
);
  localparam int SW = 2**FUNCT_W;
  logic [SW-1:0] src;
  logic sel;
  state_t tgt_d, tgt_q, st_d, st_q;
  logic [DT_W-1:0] cnt_d, cnt_q;
  logic top_d, bot_d, dead_d;
  assign src = SW'({fsig, level});
  assign sel = src[funct];
  // next target from the selected source, and FSM step toward the registered target
  always_comb begin
    tgt_d = target_of(sel, mode_t'(mode));
    st_d = st_q;
    cnt_d = cnt_q;
    if (st_q == ST_DEAD) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == DT_W'(1)) st_d = tgt_q;
    end else if (tgt_q != st_q) begin
      if (st_q == ST_OFF || dead_time == '0) st_d = tgt_q;
      else begin
        st_d = ST_DEAD;
        cnt_d = dead_time;
      end
    end
    top_d = st_d == ST_HIGH;
    bot_d = st_d != ST_LOW;
    dead_d = st_d == ST_DEAD;
  end
  // target, state, counter and pin drives all registered; reset forces OFF
  always_ff @(posedge xclk) begin
    if (reset) begin
      tgt_q <= ST_OFF;
      st_q <= ST_OFF;
      cnt_q <= '0;
      out_top <= 1'b0;
      out_bot <= 1'b1;
      dead_active <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      out_top <= top_d;
      out_bot <= bot_d;
      dead_active <= dead_d;
    end
  end
endmodule

// File: rtl/do_funct_sel_dt.sv
// do_funct_sel_dt: N independent DO channels sharing function signals and dead-time
module do_funct_sel_dt
  import do_funct_pkg::*;
#(
  parameter int NCH = 8,
  parameter int NFUNCT = 10,
  parameter int FUNCT_W = 4,
  parameter int DT_W = 8
) (
  input logic xclk,
  input logic reset,
  do_funct_sel_dt_if.slave bus
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    do_chan_dt #(.NFUNCT(NFUNCT), .FUNCT_W(FUNCT_W), .DT_W(DT_W)) u_ch (
      .xclk(xclk),
      .reset(reset),
      .funct(bus.which_function[i*FUNCT_W +: FUNCT_W]),
      .mode(bus.which_mode[2*i +: 2]),
      .level(bus.level[i]),
      .fsig(bus.function_signals_in),
      .dead_time(bus.dead_time),
      .out_top(bus.out_top[i]),
      .out_bot(bus.out_bot[i]),
      .dead_active(bus.dead_active[i])
    );
  end
endmodule

// File: tb/tb_do_funct_sel_dt.sv
// tb_do_funct_sel_dt: vector table, directed corner cases and random run against a behavioural model
module tb_do_funct_sel_dt;
  logic xclk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int drive[8];
  int tgt[8];
  int left[8];
  do_funct_sel_dt_if #(.NCH(8), .NFUNCT(10), .FUNCT_W(4), .DT_W(8)) bus ();
  do_funct_sel_dt #(.NCH(8), .NFUNCT(10), .FUNCT_W(4), .DT_W(8)) dut (
    .xclk(xclk), .reset(reset), .bus(bus)
  );
  always #5 xclk = ~xclk;

  typedef struct {
    logic [3:0] f;
    logic [1:0] m;
    logic l;
    logic [9:0] fs;
    logic top;
    logic bot;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // desired drive from the spec rules: +1 high, -1 low, 0 off
  function automatic int want(input int c);
    logic [3:0] code;
    logic l;
    int m;
    code = bus.which_function[c*4 +: 4];
    m = int'(bus.which_mode[2*c +: 2]);
    l = code == 0 ? bus.level[c] : code <= 10 ? bus.function_signals_in[int'(code) - 1] : 1'b0;
    case (m)
      0: return l ? 1 : -1;
      1: return l ? 0 : -1;
      2: return l ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_tick();
    for (int c = 0; c < 8; c++) begin
      if (reset) begin
        drive[c] = 0;
        tgt[c] = 0;
        left[c] = 0;
      end else begin
        if (left[c] > 0) begin
          left[c]--;
          if (left[c] == 0) drive[c] = tgt[c];
        end else if (tgt[c] != drive[c]) begin
          if (drive[c] == 0 || bus.dead_time == 0) drive[c] = tgt[c];
          else left[c] = int'(bus.dead_time);
        end
        tgt[c] = want(c);
      end
    end
  endtask

  task automatic step();
    logic [7:0] et, eb, ed;
    @(posedge xclk);
    #1;
    model_tick();
    for (int c = 0; c < 8; c++) begin
      et[c] = left[c] == 0 && drive[c] == 1;
      eb[c] = !(left[c] == 0 && drive[c] == -1);
      ed[c] = left[c] > 0;
    end
    chk("model_top", 32'(bus.out_top), 32'(et));
    chk("model_bot", 32'(bus.out_bot), 32'(eb));
    chk("model_dead", 32'(bus.dead_active), 32'(ed));
    chk("shoot_through", 32'(bus.out_top & ~bus.out_bot), 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic hist[100];
    tbl[0]  = '{4'h0, 2'd0, 1'b1, 10'h000, 1'b1, 1'b1};
    tbl[1]  = '{4'h0, 2'd1, 1'b1, 10'h000, 1'b0, 1'b1};
    tbl[2]  = '{4'h0, 2'd2, 1'b1, 10'h000, 1'b1, 1'b1};
    tbl[3]  = '{4'h0, 2'd3, 1'b1, 10'h000, 1'b0, 1'b1};
    tbl[4]  = '{4'h0, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[5]  = '{4'h0, 2'd1, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[6]  = '{4'h0, 2'd2, 1'b0, 10'h000, 1'b0, 1'b1};
    tbl[7]  = '{4'h0, 2'd3, 1'b0, 10'h000, 1'b0, 1'b1};
    tbl[8]  = '{4'hA, 2'd0, 1'b0, 10'h200, 1'b1, 1'b1};
    tbl[9]  = '{4'hA, 2'd0, 1'b1, 10'h1FF, 1'b0, 1'b0};
    tbl[10] = '{4'hC, 2'd0, 1'b1, 10'h3FF, 1'b0, 1'b0};
    tbl[11] = '{4'hB, 2'd0, 1'b1, 10'h3FF, 1'b0, 1'b0};
    tbl[12] = '{4'h1, 2'd0, 1'b0, 10'h001, 1'b1, 1'b1};
    tbl[13] = '{4'h5, 2'd0, 1'b0, 10'h010, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) begin
      drive[c] = 0;
      tgt[c] = 0;
      left[c] = 0;
    end
    bus.which_function = '0;
    bus.which_mode = '0;
    bus.level = '0;
    bus.function_signals_in = '0;
    bus.dead_time = '0;
    // reset held 3 cycles with random inputs, then one cycle after release
    for (int i = 0; i < 4; i++) begin
      reset = i < 3;
      bus.which_function = $urandom;
      bus.which_mode = 16'($urandom);
      bus.level = 8'($urandom);
      bus.function_signals_in = 10'($urandom);
      bus.dead_time = 8'($urandom_range(0, 5));
      step();
      chk("rst_top", 32'(bus.out_top), 32'h00);
      chk("rst_bot", 32'(bus.out_bot), 32'hFF);
      chk("rst_dead", 32'(bus.dead_active), 32'h00);
    end
    reset = 1'b0;
    // vector table on ch0, dead_time 0, others disabled
    bus.which_mode = 16'hFFFF;
    bus.dead_time = 8'd0;
    steps(8);
    foreach (tbl[k]) begin
      bus.which_function[3:0] = tbl[k].f;
      bus.which_mode[1:0] = tbl[k].m;
      bus.level[0] = tbl[k].l;
      bus.function_signals_in = tbl[k].fs;
      steps(3);
      chk($sformatf("tbl%0d_top", k), 32'(bus.out_top[0]), 32'(tbl[k].top));
      chk($sformatf("tbl%0d_bot", k), 32'(bus.out_bot[0]), 32'(tbl[k].bot));
    end
    // push-pull LOW -> HIGH with dead_time 4
    bus.which_function[3:0] = 4'h0;
    bus.which_mode[1:0] = 2'd0;
    bus.level[0] = 1'b0;
    bus.dead_time = 8'd4;
    steps(8);
    bus.level[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("pp_top%0d", i), 32'(bus.out_top[0]), 32'(i >= 6));
      chk($sformatf("pp_bot%0d", i), 32'(bus.out_bot[0]), 32'(i >= 2));
      chk($sformatf("pp_dead%0d", i), 32'(bus.dead_active[0]), 32'(i >= 2 && i <= 5));
    end
    // HIGH -> OFF (open collector, L=1) passes through DEAD of 3 cycles
    bus.dead_time = 8'd3;
    bus.which_mode[1:0] = 2'd1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("off_dead%0d", i), 32'(bus.dead_active[0]), 32'(i >= 2 && i <= 4));
      chk($sformatf("off_top%0d", i), 32'(bus.out_top[0]), 32'(i == 1));
    end
    // mid-DEAD target flip and dead_time change: full 10 cycles, exit to HIGH
    bus.which_mode[1:0] = 2'd0;
    bus.dead_time = 8'd10;
    steps(14);
    bus.level[0] = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk($sformatf("mid_dead%0d", i), 32'(bus.dead_active[0]), 32'(i >= 2 && i <= 11));
      chk($sformatf("mid_top%0d", i), 32'(bus.out_top[0]), 32'(i <= 1 || i >= 12));
      if (i == 4) begin
        bus.level[0] = 1'b1;
        bus.dead_time = 8'd2;
      end
    end
    // reset in the fifth DEAD cycle aborts to OFF on the next edge
    bus.dead_time = 8'd10;
    bus.level[0] = 1'b0;
    steps(6);
    chk("abort_pre_dead", 32'(bus.dead_active[0]), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_top", 32'(bus.out_top), 32'h00);
    chk("abort_bot", 32'(bus.out_bot), 32'hFF);
    chk("abort_dead", 32'(bus.dead_active), 32'h00);
    reset = 1'b0;
    // ch3 follows PWM with two cycles of latency, then code 0xC forces LOW
    bus.which_mode = 16'hFFFF;
    bus.which_mode[7:6] = 2'd0;
    bus.which_function[15:12] = 4'hA;
    bus.function_signals_in = '0;
    bus.dead_time = 8'd0;
    steps(4);
    for (int i = 0; i < 100; i++) begin
      if (i % 20 == 0) bus.function_signals_in[9] = ~bus.function_signals_in[9];
      hist[i] = bus.function_signals_in[9];
      step();
      if (i >= 1) chk($sformatf("pwm_top%0d", i), 32'(bus.out_top[3]), 32'(hist[i-1]));
    end
    bus.which_function[15:12] = 4'hC;
    bus.function_signals_in = '1;
    steps(3);
    chk("code_c_top", 32'(bus.out_top[3]), 32'd0);
    chk("code_c_bot", 32'(bus.out_bot[3]), 32'd0);
    // random run on all channels against the model
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.which_function = $urandom;
      if ($urandom_range(0, 7) == 0) bus.which_mode = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus.level = 8'($urandom);
      if ($urandom_range(0, 1) == 0) bus.function_signals_in ^= 10'(1 << $urandom_range(0, 9));
      if ($urandom_range(0, 63) == 0) bus.dead_time = 8'($urandom_range(0, 6));
      reset = $urandom_range(0, 499) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
